// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, multi-cycle EX hold, MEM exception flush.
// Optional stall statistics counter built only when STALL_STATS_EN is defined.
module hazard_stall_ctrl #(
    parameter int unsigned MAX_EX_STALL = 64,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_read_en_1,
    input  logic                   id_read_en_2,
    input  logic [4:0]             id_read_addr_1,
    input  logic [4:0]             id_read_addr_2,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_write_addr,
    input  logic                   ex_busy_req,
    input  logic                   mem_exception,
    input  logic [31:0]            exc_vector,
    output logic [5:0]             stall,
    output logic                   flush,
    output logic [31:0]            new_pc,
    output logic                   ex_timeout,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned   WD_W   = 16;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_EX_STALL);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_BUSY = 6'b001111;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_EX_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_nxt;
    logic            flush_nxt;
    logic [31:0]     new_pc_nxt;
    logic            lu;
    logic            src1_hit;
    logic            src2_hit;

    // Load-use: EX load writes a register ID is about to read; x0 is never a real dependency.
    always_comb begin
        src1_hit = id_read_en_1 && (id_read_addr_1 == ex_write_addr);
        src2_hit = id_read_en_2 && (id_read_addr_2 == ex_write_addr);
        lu       = ex_mem_read && (ex_write_addr != 5'd0) && (src1_hit || src2_hit);
    end

    always_comb begin
        state_nxt  = state;
        stall      = STALL_NONE;
        flush_nxt  = 1'b0;
        new_pc_nxt = new_pc;
        wd_nxt     = wd_cnt;

        case (state)
            S_RUN: begin
                if (mem_exception) begin
                    state_nxt  = S_FLUSH;
                    flush_nxt  = 1'b1;
                    new_pc_nxt = exc_vector;
                    wd_nxt     = '0;
                end else if (ex_busy_req) begin
                    stall     = STALL_BUSY;
                    state_nxt = S_EX_WAIT;
                    wd_nxt    = WD_W'(1);
                end else if (lu) begin
                    stall = STALL_LU;
                end
            end

            S_EX_WAIT: begin
                if (mem_exception) begin
                    state_nxt  = S_FLUSH;
                    flush_nxt  = 1'b1;
                    new_pc_nxt = exc_vector;
                    wd_nxt     = '0;
                end else if (ex_busy_req) begin
                    stall = STALL_BUSY;
                    if (wd_cnt < WD_MAX) begin
                        wd_nxt = wd_cnt + WD_W'(1);
                    end
                end else begin
                    // Release cycle: lu is re-evaluated only once back in RUN.
                    state_nxt = S_RUN;
                    wd_nxt    = '0;
                end
            end

            S_FLUSH: begin
                // Instructions behind the exception are being discarded, so their requests are ignored.
                state_nxt = S_RUN;
            end

            default: begin
                state_nxt = S_RUN;
                wd_nxt    = '0;
            end
        endcase

        if (rst) begin
            stall = STALL_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            wd_cnt     <= '0;
            flush      <= 1'b0;
            new_pc     <= '0;
            ex_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            wd_cnt     <= wd_nxt;
            flush      <= flush_nxt;
            new_pc     <= new_pc_nxt;
            ex_timeout <= ex_timeout || (wd_nxt == WD_MAX);
        end
    end

`ifdef STALL_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall[0] && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: default instance plus a small-parameter instance (MAX_EX_STALL=4, STALL_CNT_W=3).
module tb_hazard_stall_ctrl;

`ifdef STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_read_en_1, id_read_en_2;
    logic [4:0]  id_read_addr_1, id_read_addr_2;
    logic        ex_mem_read;
    logic [4:0]  ex_write_addr;
    logic        ex_busy_req;
    logic        mem_exception;
    logic [31:0] exc_vector;

    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b;
    logic [31:0] new_pc_a, new_pc_b;
    logic        timeout_a, timeout_b;
    logic [15:0] sc_a;
    logic [2:0]  sc_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl u_a (
        .clk(clk), .rst(rst),
        .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
        .id_read_addr_1(id_read_addr_1), .id_read_addr_2(id_read_addr_2),
        .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr),
        .ex_busy_req(ex_busy_req), .mem_exception(mem_exception), .exc_vector(exc_vector),
        .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a),
        .ex_timeout(timeout_a), .stall_cycles(sc_a)
    );

    hazard_stall_ctrl #(.MAX_EX_STALL(4), .STALL_CNT_W(3)) u_b (
        .clk(clk), .rst(rst),
        .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
        .id_read_addr_1(id_read_addr_1), .id_read_addr_2(id_read_addr_2),
        .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr),
        .ex_busy_req(ex_busy_req), .mem_exception(mem_exception), .exc_vector(exc_vector),
        .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b),
        .ex_timeout(timeout_b), .stall_cycles(sc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_read_en_1   = 1'b0;
        id_read_en_2   = 1'b0;
        id_read_addr_1 = 5'd0;
        id_read_addr_2 = 5'd0;
        ex_mem_read    = 1'b0;
        ex_write_addr  = 5'd0;
        ex_busy_req    = 1'b0;
        mem_exception  = 1'b0;
        exc_vector     = 32'd0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_mem_read    = 1'b1;
        ex_write_addr  = r;
        id_read_en_1   = 1'b1;
        id_read_addr_1 = r;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        tick();
        ex_busy_req = 1'b1;
        #2 chk("stall_in_reset", {26'd0, stall_a}, 32'h00);
        tick();
        chk("rst_flush", {31'd0, flush_a}, 32'd0);
        chk("rst_new_pc", new_pc_a, 32'd0);
        chk("rst_timeout", {31'd0, timeout_b}, 32'd0);
        chk("rst_sc_a", {16'd0, sc_a}, 32'd0);
        chk("rst_sc_b", {29'd0, sc_b}, 32'd0);

        // Load-use bubbles
        rst = 1'b0;
        clr();
        set_lu(5'd5);
        #2 chk("lu1_stall_a", {26'd0, stall_a}, 32'h07);
        chk("lu1_stall_b", {26'd0, stall_b}, 32'h07);
        tick(); clr();
        #2 chk("lu1_after", {26'd0, stall_a}, 32'h00);
        chk("lu1_flush", {31'd0, flush_a}, 32'd0);
        ex_mem_read = 1'b1; ex_write_addr = 5'd9;
        id_read_en_1 = 1'b1; id_read_addr_1 = 5'd3;
        id_read_en_2 = 1'b1; id_read_addr_2 = 5'd9;
        #2 chk("lu2_src2", {26'd0, stall_a}, 32'h07);
        tick();
        id_read_en_2 = 1'b0;
        #2 chk("lu_no_read_en", {26'd0, stall_a}, 32'h00);
        tick();
        ex_mem_read = 1'b0; id_read_en_1 = 1'b1; id_read_addr_1 = 5'd9;
        #2 chk("lu_not_load", {26'd0, stall_a}, 32'h00);
        tick(); clr();
        ex_mem_read = 1'b1; ex_write_addr = 5'd0;
        id_read_en_1 = 1'b1; id_read_en_2 = 1'b1;
        #2 chk("lu_x0", {26'd0, stall_a}, 32'h00);
        tick();
        #2 chk("lu_x0_next", {26'd0, stall_a}, 32'h00);
        tick(); clr();
        set_lu(5'd31);
        #2 chk("lu3_r31", {26'd0, stall_a}, 32'h07);
        tick(); clr();

        // Five busy cycles: small instance times out after its 4th
        ex_busy_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2 chk("busy5_stall", {26'd0, stall_a}, 32'h0F);
            tick();
            if (i == 2) chk("timeout_b_3", {31'd0, timeout_b}, 32'd0);
            if (i == 3) chk("timeout_b_4", {31'd0, timeout_b}, 32'd1);
        end
        ex_busy_req = 1'b0;
        set_lu(5'd7);
        #2 chk("busy_release_ignores_lu", {26'd0, stall_a}, 32'h00);
        tick(); clr();
        chk("sc_a_8", {16'd0, sc_a}, STATS ? 32'd8 : 32'd0);
        chk("sc_b_sat", {29'd0, sc_b}, STATS ? 32'd7 : 32'd0);
        chk("timeout_b_sticky", {31'd0, timeout_b}, 32'd1);
        chk("timeout_a_clear", {31'd0, timeout_a}, 32'd0);
        set_lu(5'd7);
        #2 chk("lu_resumes", {26'd0, stall_a}, 32'h07);
        tick(); clr();

        // Ten busy cycles on the default instance: no timeout
        ex_busy_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #2 chk("busy10_stall", {26'd0, stall_a}, 32'h0F);
            tick();
        end
        ex_busy_req = 1'b0;
        #2 chk("busy10_cycle11", {26'd0, stall_a}, 32'h00);
        tick();
        chk("busy10_timeout_a", {31'd0, timeout_a}, 32'd0);

        // Exception in RUN beats busy and load-use
        mem_exception = 1'b1; exc_vector = 32'hBFC00380;
        ex_busy_req = 1'b1; set_lu(5'd4);
        #2 chk("exc_run_stall", {26'd0, stall_a}, 32'h00);
        tick(); clr();
        chk("exc_run_flush", {31'd0, flush_a}, 32'd1);
        chk("exc_run_new_pc", new_pc_a, 32'hBFC00380);
        mem_exception = 1'b1; exc_vector = 32'h12345678; ex_busy_req = 1'b1;
        #2 chk("flush_stall", {26'd0, stall_a}, 32'h00);
        tick(); clr();
        chk("flush_drop", {31'd0, flush_a}, 32'd0);
        chk("new_pc_hold", new_pc_a, 32'hBFC00380);
        set_lu(5'd4);
        #2 chk("post_flush_run", {26'd0, stall_a}, 32'h07);
        tick(); clr();
        chk("flush_once", {31'd0, flush_a}, 32'd0);

        // Exception during EX_WAIT
        ex_busy_req = 1'b1;
        #2 chk("exw_enter", {26'd0, stall_a}, 32'h0F);
        tick();
        mem_exception = 1'b1; exc_vector = 32'h80000180;
        #2 chk("exw_exc_stall", {26'd0, stall_a}, 32'h00);
        tick(); clr();
        chk("exw_flush", {31'd0, flush_a}, 32'd1);
        chk("exw_new_pc", new_pc_a, 32'h80000180);
        tick();
        chk("exw_flush_drop", {31'd0, flush_a}, 32'd0);
        chk("sc_a_21", {16'd0, sc_a}, STATS ? 32'd21 : 32'd0);

        // Reset while in EX_WAIT
        ex_busy_req = 1'b1;
        tick();
        rst = 1'b1;
        #2 chk("rst_mid_stall", {26'd0, stall_a}, 32'h00);
        tick();
        rst = 1'b0; clr();
        chk("rst_mid_flush", {31'd0, flush_a}, 32'd0);
        chk("rst_mid_new_pc", new_pc_a, 32'd0);
        chk("rst_mid_timeout_b", {31'd0, timeout_b}, 32'd0);
        chk("rst_mid_sc_a", {16'd0, sc_a}, 32'd0);
        chk("rst_mid_sc_b", {29'd0, sc_b}, 32'd0);
        set_lu(5'd12);
        #2 chk("rst_mid_run", {26'd0, stall_a}, 32'h07);
        tick(); clr();

        // Nine busy cycles: 3-bit counter saturates
        ex_busy_req = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        ex_busy_req = 1'b0;
        tick();
        chk("sat_sc_b", {29'd0, sc_b}, STATS ? 32'd7 : 32'd0);
        chk("sat_sc_a", {16'd0, sc_a}, STATS ? 32'd10 : 32'd0);
        chk("sat_timeout_b", {31'd0, timeout_b}, 32'd1);
        chk("sat_timeout_a", {31'd0, timeout_a}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline controller for the 5-stage MIPS core.
- Detects load-use hazards that EX/MEM forwarding cannot resolve, and holds the pipeline while a multi-cycle EX operation completes.
- Sequences the pipeline flush and PC redirect on a MEM-stage exception.
- Drives the per-stage stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- MAX_EX_STALL, 64: cycles in EX_WAIT before ex_timeout is raised (range 2..65535).
- STALL_CNT_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- id_read_en_1  in  1  ID operand 1 reads the register file.
- id_read_en_2  in  1  ID operand 2 reads the register file.
- id_read_addr_1  in  5  ID operand 1 register address.
- id_read_addr_2  in  5  ID operand 2 register address.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_write_addr  in  5  destination register of the EX instruction.
- ex_busy_req  in  1  EX multi-cycle operation not yet done.
- mem_exception  in  1  MEM stage raises an exception this cycle.
- exc_vector  in  32  handler address for mem_exception.
- stall  out  6  hold per stage: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB.
- flush  out  1  clear all pipeline registers.
- new_pc  out  32  redirect PC, valid while flush=1.
- ex_timeout  out  1  sticky: EX held for MAX_EX_STALL cycles.
- stall_cycles  out  STALL_CNT_W  count of cycles with stall[0]=1.

Behaviour:
- FSM states are RUN, EX_WAIT and FLUSH. Reset state is RUN.
- Reset values: flush=0, new_pc=0, ex_timeout=0, stall_cycles=0, watchdog counter=0. stall is forced to 0 while rst=1.
- stall is combinational from the current state and inputs. flush and new_pc are registered.
- Load-use hazard, lu:
  - lu = ex_mem_read && ex_write_addr!=0 && ((id_read_en_1 && id_read_addr_1==ex_write_addr) || (id_read_en_2 && id_read_addr_2==ex_write_addr)).
- RUN, priority highest first:
  1. mem_exception=1: stall=0; next state FLUSH; latch exc_vector into new_pc; flush=1 in the next cycle.
  2. ex_busy_req=1: stall=6'b001111 in the same cycle; next state EX_WAIT; watchdog counter set to 1.
  3. lu=1: stall=6'b000111 for that cycle only, so EX receives a bubble. State stays RUN. The following cycle the load is in MEM and forwarding resolves the hazard.
  4. Otherwise stall=0.
- EX_WAIT:
  - mem_exception=1 takes precedence: same action as in RUN; watchdog counter cleared.
  - Otherwise, while ex_busy_req=1: stall=6'b001111 and the watchdog counter increments. When the counter reaches MAX_EX_STALL, ex_timeout is set and remains 1 until rst. The counter saturates at MAX_EX_STALL.
  - ex_busy_req=0: stall=0 in that cycle; return to RUN; watchdog counter cleared. The lu check resumes from the next cycle.
- FLUSH:
  - Lasts exactly one cycle: flush=1, stall=0, new_pc=latched vector.
  - mem_exception and ex_busy_req are ignored, because those instructions are being flushed.
  - Next state RUN; flush returns to 0; new_pc holds its value.
- Simultaneous lu and ex_busy_req: the busy stall pattern applies, since it is a superset.
- rst asserted mid-EX_WAIT or mid-FLUSH: next cycle is RUN with all registered outputs at their reset values.
- x0 destination (ex_write_addr=0) never produces a load-use stall.

Optional Feature:
- Macro STALL_STATS_EN.
- When defined: stall_cycles increments by 1 each cycle with stall[0]=1, saturates at all-ones, and clears only on rst.
- When undefined: no counter logic is built and stall_cycles is tied to 0.

Test Plan:
- Load-use: ex_mem_read=1, ex_write_addr=5, id_read_en_1=1, id_read_addr_1=5 for one cycle -> stall=6'b000111 that cycle, stall=0 the next, state stays RUN.
- Load to x0: ex_write_addr=0, id_read_addr_2=0, id_read_en_2=1 -> stall=0 throughout.
- Multi-cycle EX: ex_busy_req high for 10 cycles -> stall=6'b001111 for 10 cycles, stall=0 on cycle 11, ex_timeout=0. With MAX_EX_STALL=4, holding busy for 6 cycles -> ex_timeout=1 from cycle 4 and remains set after busy drops.
- Exception: mem_exception=1 with exc_vector=32'hBFC00380 in RUN -> next cycle flush=1 and new_pc=32'hBFC00380 for exactly one cycle, then flush=0. An exception during EX_WAIT -> identical flush, and stall drops to 0 in the exception cycle.
- Reset mid-operation: rst=1 during EX_WAIT -> next cycle stall=0, flush=0, ex_timeout=0, stall_cycles=0, state RUN.
- STALL_STATS_EN defined: 3 load-use stalls plus 5 busy cycles -> stall_cycles=8. With STALL_CNT_W=3, 9 stall cycles -> value saturates at 7.
